// File: rtl/seq_shifter.sv
// Multicycle shifter: one bit position per clock, one-cycle done pulse at completion.
// Rotates (ROR/ROL) are built only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise they decode as NOP.
module seq_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         shift_op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  logic [1:0]         state_q,  state_d;
  logic [2:0]         op_q,     op_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               is_shift_op;

  // Single 1-bit step of the latched operation.
  function automatic logic [WIDTH-1:0] step1(input logic [2:0] op, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      OP_SLL: r = {v[WIDTH-2:0], 1'b0};
      OP_SRL: r = {1'b0, v[WIDTH-1:1]};
      OP_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROR: r = {v[0], v[WIDTH-1:1]};
      OP_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
`endif
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    is_shift_op = 1'b0;
    case (shift_op)
      OP_SLL, OP_SRL, OP_SRA: is_shift_op = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROR, OP_ROL:         is_shift_op = 1'b1;
`endif
      default:                is_shift_op = 1'b0;
    endcase
  end

  // Next-state, counter and working-register update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_SHIFT: begin
        result_d = step1(op_q, result_q);
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
      end
      default: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          op_d    = shift_op;
          state_d = ST_DONE;
          if (shift_op == OP_LOAD) begin
            result_d = data_in;
          end else if (is_shift_op) begin
            result_d = data_in;
            cnt_d    = shamt;
            if (shamt != '0) state_d = ST_SHIFT;
          end
        end
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (32-bit); rotate expectations follow SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  shift_op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int lat, bcnt, ovl, dcnt;

  seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .shift_op(shift_op),
    .data_in(data_in), .shamt(shamt), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a start across one edge (edge k), then drop it and scramble operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s);
    shift_op = op; data_in = d; shamt = s; start = 1'b1;
    step();
    start = 1'b0; data_in = 32'h5A5A_A5A5; shamt = 5'd7; shift_op = 3'b111;
  endtask

  // Edges after edge k until done is seen; busy cycles and busy&done overlaps counted.
  task automatic wait_done(output int l, output int b, output int o);
    l = 0; b = 0; o = 0;
    while (done !== 1'b1 && l <= 64) begin
      if (busy === 1'b1) b++;
      step();
      l++;
    end
    if (busy === 1'b1 && done === 1'b1) o++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; shift_op = 3'b000; data_in = '0; shamt = '0;
    step(); step();
    reset = 1'b0;
    check("reset_result", result, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);

    issue(3'b010, 32'h0000_0001, 5'd4);
    wait_done(lat, bcnt, ovl);
    check("sll_lat", lat, 4);
    check("sll_busy", bcnt, 4);
    check("sll_ovl", ovl, 0);
    check("sll_result", result, 32'h0000_0010);
    step();
    check("sll_done_drop", {31'b0, done}, 32'h0);

    issue(3'b100, 32'h8000_0000, 5'd31);
    wait_done(lat, bcnt, ovl);
    check("sra_lat", lat, 31);
    check("sra_busy", bcnt, 31);
    check("sra_result", result, 32'hFFFF_FFFF);
    // Back-to-back start while in DONE
    issue(3'b011, 32'h8000_0000, 5'd31);
    check("b2b_done_drop", {31'b0, done}, 32'h0);
    wait_done(lat, bcnt, ovl);
    check("srl_lat", lat, 31);
    check("srl_result", result, 32'h0000_0001);

    issue(3'b001, 32'hDEAD_BEEF, 5'd9);
    wait_done(lat, bcnt, ovl);
    check("load_lat", lat, 0);
    check("load_result", result, 32'hDEAD_BEEF);
    issue(3'b000, 32'h1111_1111, 5'd3);
    wait_done(lat, bcnt, ovl);
    check("nop_lat", lat, 0);
    check("nop_result", result, 32'hDEAD_BEEF);
    issue(3'b111, 32'h2222_2222, 5'd3);
    wait_done(lat, bcnt, ovl);
    check("rsv_lat", lat, 0);
    check("rsv_result", result, 32'hDEAD_BEEF);

    issue(3'b010, 32'h0000_1234, 5'd0);
    check("sll0_busy", {31'b0, busy}, 32'h0);
    wait_done(lat, bcnt, ovl);
    check("sll0_lat", lat, 0);
    check("sll0_result", result, 32'h0000_1234);
    step();

    issue(3'b010, 32'h0000_0003, 5'd3);
    step();
    shift_op = 3'b011; data_in = 32'hFFFF_0000; shamt = 5'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, bcnt, ovl);
    check("ign_lat", lat, 1);
    check("ign_result", result, 32'h0000_0018);
    step();

    issue(3'b011, 32'h0000_00F0, 5'd8);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_done", {31'b0, done}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("rst_no_done", dcnt, 0);

    issue(3'b101, 32'h0000_0001, 5'd1);
    wait_done(lat, bcnt, ovl);
`ifdef SEQ_SHIFTER_ROTATE_EN
    check("ror_lat", lat, 1);
    check("ror_result", result, 32'h8000_0000);
    step();
    issue(3'b110, 32'h8000_0001, 5'd4);
    wait_done(lat, bcnt, ovl);
    check("rol_lat", lat, 4);
    check("rol_result", result, 32'h0000_0018);
`else
    check("ror_lat", lat, 0);
    check("ror_result", result, 32'h0000_0000);
    step();
    issue(3'b110, 32'h8000_0001, 5'd4);
    wait_done(lat, bcnt, ovl);
    check("rol_lat", lat, 0);
    check("rol_result", result, 32'h0000_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
